password_entry: RTL and testbench

Keypad-side front end of the digital lock; it produces the pass_in/pass_set/enb operands consumed by comparator_12bit.
- Collects three BCD digits from the keypad into a 12-bit code.
- In set mode, stores that code as the password.
- Otherwise drives a check window and samples the comparator's lock verdict.
- Counts failed attempts and enforces a timed lockout.

---
 rtl/password_entry.sv | 184 ++++++++++++++++++
 tb/tb_password_entry.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/password_entry.sv
// password_entry: keypad front end of the digital lock.
// Collects three BCD digits into a 12-bit code. In set mode the code becomes
// the stored password. Otherwise the module opens a comparator check window
// and samples the lock verdict. It also counts failed attempts and enforces a
// timed lockout.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   key_valid/key_code    digit strobe and value (only 0..9 accepted)
//   key_enter/key_clear   submit / discard strobes
//   mode_set              1 = submitted code is stored as the new password
//   lock                  comparator verdict (1 = mismatch), valid while enb=1
//   pass_in, pass_set     candidate and stored codes to the comparator
//   enb                   comparator enable (check window)
//   digit_cnt             digits currently buffered (0..3)
//   lockout               high while attempts are locked out
//   unlock_ok, set_done, entry_err   one-cycle result pulses
//
// Optional feature macro: AUTO_ENTER_EN. When it is defined, accepting the
// third digit submits the entry automatically on the following cycle.
module password_entry #(
  parameter logic [11:0] DEFAULT_PASS   = 12'h123,
  parameter int unsigned CHECK_WAIT     = 2,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        key_enter,
  input  logic        key_clear,
  input  logic        mode_set,
  input  logic        lock,
  output logic [11:0] pass_in,
  output logic [11:0] pass_set,
  output logic        enb,
  output logic [1:0]  digit_cnt,
  output logic        lockout,
  output logic        unlock_ok,
  output logic        set_done,
  output logic        entry_err
);

  localparam int unsigned WAIT_W = (CHECK_WAIT > 1) ? $clog2(CHECK_WAIT) : 1;
  localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_LOCKOUT = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [11:0]       entry_buf, buf_nxt;
  logic [1:0]        cnt_nxt;
  logic [11:0]       pass_in_nxt, pass_set_nxt;
  logic [FAIL_W-1:0] fail_cnt, fail_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
  logic              ok_nxt, done_nxt, err_nxt;
  logic              enter_req;

`ifdef AUTO_ENTER_EN
  // Pending implicit enter, raised when the third digit is accepted.
  logic auto_pend, auto_nxt;
  assign enter_req = key_enter | auto_pend;
`else
  assign enter_req = key_enter;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      entry_buf <= 12'h000;
      digit_cnt <= 2'd0;
      pass_in   <= 12'h000;
      pass_set  <= DEFAULT_PASS;
      fail_cnt  <= '0;
      wait_cnt  <= '0;
      lock_cnt  <= '0;
      enb       <= 1'b0;
      lockout   <= 1'b0;
      unlock_ok <= 1'b0;
      set_done  <= 1'b0;
      entry_err <= 1'b0;
`ifdef AUTO_ENTER_EN
      auto_pend <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      entry_buf <= buf_nxt;
      digit_cnt <= cnt_nxt;
      pass_in   <= pass_in_nxt;
      pass_set  <= pass_set_nxt;
      fail_cnt  <= fail_nxt;
      wait_cnt  <= wait_nxt;
      lock_cnt  <= lock_cnt_nxt;
      enb       <= (state_nxt == S_CHECK);
      lockout   <= (state_nxt == S_LOCKOUT);
      unlock_ok <= ok_nxt;
      set_done  <= done_nxt;
      entry_err <= err_nxt;
`ifdef AUTO_ENTER_EN
      auto_pend <= auto_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    buf_nxt      = entry_buf;
    cnt_nxt      = digit_cnt;
    pass_in_nxt  = pass_in;
    pass_set_nxt = pass_set;
    fail_nxt     = fail_cnt;
    wait_nxt     = wait_cnt;
    lock_cnt_nxt = lock_cnt;
    ok_nxt       = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
`ifdef AUTO_ENTER_EN
    auto_nxt     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // Priority: clear > enter > digit.
        if (key_clear) begin
          buf_nxt = 12'h000;
          cnt_nxt = 2'd0;
        end else if (enter_req) begin
          buf_nxt = 12'h000;
          cnt_nxt = 2'd0;
          if (digit_cnt != 2'd3) begin
            err_nxt = 1'b1;
          end else if (mode_set) begin
            pass_set_nxt = entry_buf;
            done_nxt     = 1'b1;
          end else begin
            pass_in_nxt = entry_buf;
            wait_nxt    = '0;
            state_nxt   = S_CHECK;
          end
        end else if (key_valid && (key_code <= 4'd9) && (digit_cnt != 2'd3)) begin
          buf_nxt = {entry_buf[7:0], key_code};
          cnt_nxt = digit_cnt + 2'd1;
`ifdef AUTO_ENTER_EN
          auto_nxt = (digit_cnt == 2'd2);
`endif
        end
      end
      S_CHECK: begin
        // The verdict is taken on the last cycle of the enb window.
        if (wait_cnt == WAIT_W'(CHECK_WAIT - 1)) begin
          if (!lock) begin
            ok_nxt    = 1'b1;
            fail_nxt  = '0;
            state_nxt = S_IDLE;
          end else if (fail_cnt >= FAIL_W'(MAX_FAIL - 1)) begin
            fail_nxt     = FAIL_W'(MAX_FAIL);
            lock_cnt_nxt = '0;
            state_nxt    = S_LOCKOUT;
          end else begin
            fail_nxt  = fail_cnt + FAIL_W'(1);
            state_nxt = S_IDLE;
          end
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_LOCKOUT: begin
        if (lock_cnt == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
          fail_nxt  = '0;
          state_nxt = S_IDLE;
        end else begin
          lock_cnt_nxt = lock_cnt + LOCK_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_password_entry.sv
// Directed self-checking bench for password_entry (LOCKOUT_CYCLES = 20).
module tb_password_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        key_enter = 1'b0;
  logic        key_clear = 1'b0;
  logic        mode_set = 1'b0;
  logic        lock;
  logic [11:0] pass_in, pass_set;
  logic        enb, lockout, unlock_ok, set_done, entry_err;
  logic [1:0]  digit_cnt;

  int checks = 0;
  int errors = 0;
  int en_n, ok_n, lo_n;

  password_entry #(
    .DEFAULT_PASS(12'h123), .CHECK_WAIT(2), .MAX_FAIL(3), .LOCKOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_enter(key_enter), .key_clear(key_clear), .mode_set(mode_set),
    .lock(lock), .pass_in(pass_in), .pass_set(pass_set), .enb(enb),
    .digit_cnt(digit_cnt), .lockout(lockout), .unlock_ok(unlock_ok),
    .set_done(set_done), .entry_err(entry_err)
  );

  // Comparator model: mismatch means locked.
  assign lock = (pass_in != pass_set);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_code  = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic enter(input logic m);
    key_enter = 1'b1;
    mode_set  = m;
    step();
    key_enter = 1'b0;
    mode_set  = 1'b0;
  endtask

  task automatic code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    press(a);
    press(b);
    press(c);
  endtask

  // Sample n cycles from now, counting enb / unlock_ok / lockout highs.
  task automatic window(input int n, output int en_c, output int ok_c, output int lo_c);
    en_c = 0; ok_c = 0; lo_c = 0;
    for (int s = 0; s < n; s++) begin
      if (enb) en_c++;
      if (unlock_ok) ok_c++;
      if (lockout) lo_c++;
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pass_in"}, 32'(pass_in), 32'h000);
    chk({tag, "_pass_set"}, 32'(pass_set), 32'h123);
    chk({tag, "_enb"}, 32'(enb), 0);
    chk({tag, "_digit_cnt"}, 32'(digit_cnt), 0);
    chk({tag, "_lockout"}, 32'(lockout), 0);
    chk({tag, "_pulses"}, 32'({unlock_ok, set_done, entry_err}), 0);
  endtask

  initial begin
    // 1: reset, then correct code unlocks
    do_reset();
    chk_reset_vals("rst");
    code(4'd1, 4'd2, 4'd3);
    chk("t1_digits", 32'(digit_cnt), 3);
    enter(1'b0);
    chk("t1_pass_in", 32'(pass_in), 32'h123);
    chk("t1_enb_first", 32'(enb), 1);
    window(6, en_n, ok_n, lo_n);
    chk("t1_enb_cycles", en_n, 2);
    chk("t1_unlock_pulses", ok_n, 1);
    chk("t1_lockout", lo_n, 0);

    // 2: set new password 432, then 123 is rejected
    code(4'd4, 4'd3, 4'd2);
    enter(1'b1);
    chk("t2_set_done", 32'(set_done), 1);
    chk("t2_pass_set", 32'(pass_set), 32'h432);
    chk("t2_enb", 32'(enb), 0);
    step();
    chk("t2_set_done_drop", 32'(set_done), 0);
    code(4'd1, 4'd2, 4'd3);
    enter(1'b0);
    window(6, en_n, ok_n, lo_n);
    chk("t2_enb_cycles", en_n, 2);
    chk("t2_no_unlock", ok_n, 0);

    // 3: three wrong entries -> 20-cycle lockout, keys ignored during it
    do_reset();
    for (int k = 0; k < 2; k++) begin
      code(4'd9, 4'd9, 4'd9);
      enter(1'b0);
      window(6, en_n, ok_n, lo_n);
      chk("t3_wrong_ok", ok_n, 0);
      chk("t3_wrong_lo", lo_n, 0);
    end
    code(4'd9, 4'd9, 4'd9);
    enter(1'b0);
    en_n = 0; lo_n = 0;
    for (int s = 0; s < 26; s++) begin
      if (enb) en_n++;
      if (lockout) lo_n++;
      if (s >= 2 && s <= 21) begin
        key_valid = 1'b1;
        key_code  = 4'(s % 10);
        key_enter = (s % 3 == 0);
        mode_set  = 1'b1;
      end else begin
        key_valid = 1'b0;
        key_enter = 1'b0;
        mode_set  = 1'b0;
      end
      step();
    end
    key_valid = 1'b0; key_enter = 1'b0; mode_set = 1'b0;
    chk("t3_lockout_cycles", lo_n, 20);
    chk("t3_third_enb", en_n, 2);
    chk("t3_keys_ignored_cnt", 32'(digit_cnt), 0);
    chk("t3_keys_ignored_set", 32'(pass_set), 32'h123);
    code(4'd1, 4'd2, 4'd3);
    enter(1'b0);
    window(6, en_n, ok_n, lo_n);
    chk("t3_unlock_after", ok_n, 1);

    // 4: short entry error; overflow / invalid digits ignored
    press(4'd1);
    press(4'd2);
    enter(1'b0);
    chk("t4_entry_err", 32'(entry_err), 1);
    chk("t4_digits_cleared", 32'(digit_cnt), 0);
    chk("t4_enb", 32'(enb), 0);
    step();
    chk("t4_err_drop", 32'(entry_err), 0);
    chk("t4_enb_later", 32'(enb), 0);
    code(4'd5, 4'd5, 4'd5);
    enter(1'b0);
    window(6, en_n, ok_n, lo_n);
    chk("t4_555_rejected", ok_n, 0);
    code(4'd1, 4'd2, 4'd3);
    press(4'd4);
    press(4'd11);
    chk("t4_digits_sat", 32'(digit_cnt), 3);
    enter(1'b0);
    chk("t4_buffer", 32'(pass_in), 32'h123);
    window(6, en_n, ok_n, lo_n);
    chk("t4_unlock", ok_n, 1);

    // 5: clear beats enter and digit on the same cycle
    code(4'd1, 4'd2, 4'd3);
    key_valid = 1'b1; key_code = 4'd5; key_enter = 1'b1; key_clear = 1'b1; mode_set = 1'b1;
    step();
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; mode_set = 1'b0;
    chk("t5_clear_cnt", 32'(digit_cnt), 0);
    chk("t5_clear_enb", 32'(enb), 0);
    chk("t5_clear_set_done", 32'(set_done), 0);
    chk("t5_clear_pass_set", 32'(pass_set), 32'h123);

    // 5b: reset in the middle of a check
    code(4'd4, 4'd3, 4'd2);
    enter(1'b1);
    code(4'd1, 4'd2, 4'd3);
    enter(1'b0);
    chk("t5_in_check", 32'(enb), 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("t5_rst_check");
    rst = 1'b0;
    step();

    // 5c: reset in the middle of a lockout
    for (int k = 0; k < 3; k++) begin
      code(4'd9, 4'd9, 4'd9);
      enter(1'b0);
      window(4, en_n, ok_n, lo_n);
    end
    chk("t5_in_lockout", 32'(lockout), 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("t5_rst_lockout");
    rst = 1'b0;
    step();

    // 6: auto-enter after the third digit (only with AUTO_ENTER_EN)
    code(4'd1, 4'd2, 4'd3);
    chk("t6_enb_k1", 32'(enb), 0);
    step();
`ifdef AUTO_ENTER_EN
    chk("t6_enb_k2", 32'(enb), 1);
    window(6, en_n, ok_n, lo_n);
    chk("t6_auto_unlock", ok_n, 1);
    chk("t6_auto_digits", 32'(digit_cnt), 0);
`else
    chk("t6_enb_k2", 32'(enb), 0);
    window(6, en_n, ok_n, lo_n);
    chk("t6_no_auto_enb", en_n, 0);
    chk("t6_no_auto_digits", 32'(digit_cnt), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
